// File: rtl/game_pkg.sv
// Shared game-level constants: top-state codes, W_or_L encodings, bonus/world constants.
// Also holds the obstacle LFSR step used by the world sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        PresOff  = 3'd0,
        PresWlcm = 3'd1,
        PresCh   = 3'd2,
        PresGame = 3'd3,
        PresWl   = 3'd4,
        PresPa   = 3'd5
    } presente_e;

    // {win, lose} as seen on W_or_L
    localparam logic [1:0] WolNone = 2'b00;
    localparam logic [1:0] WolLose = 2'b01;
    localparam logic [1:0] WolWin  = 2'b10;

    localparam logic [4:0] BonusType  = 5'd16;
    localparam logic [1:0] WorldCount = 2'd3;
    localparam int unsigned DivWidth  = 28;

    function automatic logic [3:0] lfsr_step(input logic [3:0] r);
        return {r[3] ^ r[2] ^ r[0], r[3:1]};
    endfunction

endpackage

// File: rtl/world_sequencer_if.sv
// Bus between the game controller (master) and the world sequencer (slave).
interface world_sequencer_if;

    logic [2:0] presente;
    logic       bono_tomado;
    logic       collision;
    logic       tick;
    logic       spawn;
    logic [3:0] spawn_type;
    logic       bonus_spawn;
    logic [1:0] world;
    logic [6:0] remaining;
    logic       win;
    logic       lose;

    modport master (
        output presente, bono_tomado, collision,
        input  tick, spawn, spawn_type, bonus_spawn, world, remaining, win, lose
    );

    modport slave (
        input  presente, bono_tomado, collision,
        output tick, spawn, spawn_type, bonus_spawn, world, remaining, win, lose
    );

endinterface

// File: rtl/tick_divider.sv
// Obstacle tick generator: counts to i_div-1, wraps and emits a registered one-cycle tick.
module tick_divider
    import game_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_hold,
    input  logic [DivWidth-1:0] i_div,
    output logic                o_wrap,
    output logic                o_tick
);

    logic [DivWidth-1:0] r_cnt;
    logic                r_tick;
    logic [DivWidth-1:0] w_last;

    assign w_last = i_div - DivWidth'(1);
    assign o_wrap = (r_cnt == w_last);
    assign o_tick = r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_hold) begin
            r_tick <= 1'b0;
        end else if (o_wrap) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + DivWidth'(1);
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/world_sequencer.sv
// Obstacle cadence, per-world budget, bonus placement and win/lose progression.
// Define WORLD_SEQ_FAST_SIM_EN for dividers 8/6/5 and a fixed LFSR seed of 1.
module world_sequencer
    import game_pkg::*;
#(
    parameter int unsigned DIV_W1 = 18000000,
    parameter int unsigned DIV_W2 = 13500000,
    parameter int unsigned DIV_W3 = 10800000,
    parameter int unsigned OBS_W1 = 15,
    parameter int unsigned OBS_W2 = 20,
    parameter int unsigned OBS_W3 = 25
) (
    input logic              clk,
    input logic              rst_n,
    world_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StBonusWait,
        StPaused,
        StDoneWin,
        StDoneLose
    } state_e;

    logic [3:0] w_seed;

`ifdef WORLD_SEQ_FAST_SIM_EN
    localparam int unsigned DivW1 = 8;
    localparam int unsigned DivW2 = 6;
    localparam int unsigned DivW3 = 5;

    assign w_seed = 4'd1;
`else
    localparam int unsigned DivW1 = DIV_W1;
    localparam int unsigned DivW2 = DIV_W2;
    localparam int unsigned DivW3 = DIV_W3;

    logic [3:0] r_seed_cnt;

    // Free-running 1..15 so the seed is never the LFSR lock-up value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seed_cnt <= 4'd1;
        end else begin
            r_seed_cnt <= (r_seed_cnt == 4'd15) ? 4'd1 : r_seed_cnt + 4'd1;
        end
    end

    assign w_seed = r_seed_cnt;
`endif

    state_e     r_state, w_state_d;
    state_e     r_ret, w_ret_d;
    state_e     w_cur;
    logic [1:0] r_world, w_world_d;
    logic [6:0] r_remaining, w_remaining_d;
    logic [1:0] r_phase, w_phase_d;
    logic [3:0] r_lfsr, w_lfsr_d;
    logic       r_spawn, w_spawn_d;
    logic       r_bonus, w_bonus_d;
    logic [3:0] r_spawn_type, w_spawn_type_d;
    logic       r_win, w_win_d;
    logic       r_lose, w_lose_d;
    logic       r_bono_q;

    logic                w_game;
    logic                w_pause;
    logic                w_bono_rise;
    logic                w_adv;
    logic                w_wrap;
    logic                w_tick;
    logic                w_clr;
    logic [DivWidth-1:0] w_div;
    logic [6:0]          w_budget;

    assign w_game      = (bus.presente == PresGame);
    assign w_pause     = (bus.presente == PresPa);
    assign w_bono_rise = bus.bono_tomado & ~r_bono_q;
    assign w_clr       = (r_state == StIdle) || (r_state == StLoad);

    always_comb begin
        unique case (r_world)
            2'd0: begin
                w_div    = DivWidth'(DivW1);
                w_budget = 7'(OBS_W1);
            end
            2'd1: begin
                w_div    = DivWidth'(DivW2);
                w_budget = 7'(OBS_W2);
            end
            default: begin
                w_div    = DivWidth'(DivW3);
                w_budget = 7'(OBS_W3);
            end
        endcase
    end

    tick_divider u_tick_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_hold (~w_adv),
        .i_div  (w_div),
        .o_wrap (w_wrap),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_d      = r_state;
        w_ret_d        = r_ret;
        w_cur          = r_state;
        w_world_d      = r_world;
        w_remaining_d  = r_remaining;
        w_phase_d      = r_phase;
        w_lfsr_d       = r_lfsr;
        w_spawn_d      = 1'b0;
        w_bonus_d      = 1'b0;
        w_spawn_type_d = r_spawn_type;
        w_win_d        = r_win;
        w_lose_d       = r_lose;
        w_adv          = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_game) w_state_d = StLoad;
            end
            StLoad: begin
                w_remaining_d = w_budget;
                w_lfsr_d      = w_seed;
                w_phase_d     = 2'd0;
                w_state_d     = (w_game || w_pause) ? StRun : StIdle;
            end
            StRun, StBonusWait, StPaused: begin
                if (w_pause) begin
                    if (r_state != StPaused) begin
                        w_state_d = StPaused;
                        w_ret_d   = r_state;
                    end
                end else if (!w_game) begin
                    w_state_d = StIdle;
                end else if (r_state != StPaused && bus.collision) begin
                    w_state_d = StDoneLose;
                    w_lose_d  = 1'b1;
                end else if (r_state != StPaused && w_bono_rise) begin
                    w_world_d = r_world + 2'd1;
                    if (w_world_d == WorldCount) begin
                        w_state_d = StDoneWin;
                        w_win_d   = 1'b1;
                    end else begin
                        w_state_d = StLoad;
                    end
                end else begin
                    // The resume cycle counts, so a pause stretches spacing by exactly its length
                    w_adv     = 1'b1;
                    w_cur     = (r_state == StPaused) ? r_ret : r_state;
                    w_state_d = w_cur;
                    if (w_wrap && w_cur == StRun) begin
                        w_remaining_d = r_remaining - 7'd1;
                        w_bonus_d     = (r_remaining == 7'd2);
                        if (r_remaining == 7'd1) begin
                            w_spawn_d      = 1'b1;
                            w_spawn_type_d = r_lfsr;
                            w_phase_d      = 2'd0;
                        end else begin
                            if (r_phase[0]) begin
                                w_lfsr_d = lfsr_step(r_lfsr);
                            end else if (r_remaining != 7'd2) begin
                                w_spawn_d      = 1'b1;
                                w_spawn_type_d = r_lfsr;
                            end
                            w_phase_d = r_phase + 2'd1;
                        end
                        if (w_remaining_d == 7'd0) w_state_d = StBonusWait;
                    end
                end
            end
            default: begin
                if (!w_game && !w_pause) w_state_d = StIdle;
            end
        endcase

        if (w_state_d == StIdle) begin
            w_world_d      = 2'd0;
            w_remaining_d  = 7'd0;
            w_phase_d      = 2'd0;
            w_spawn_type_d = 4'd0;
            w_win_d        = 1'b0;
            w_lose_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_ret        <= StRun;
            r_world      <= 2'd0;
            r_remaining  <= 7'd0;
            r_phase      <= 2'd0;
            r_lfsr       <= 4'd1;
            r_spawn      <= 1'b0;
            r_bonus      <= 1'b0;
            r_spawn_type <= 4'd0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
            r_bono_q     <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_ret        <= w_ret_d;
            r_world      <= w_world_d;
            r_remaining  <= w_remaining_d;
            r_phase      <= w_phase_d;
            r_lfsr       <= w_lfsr_d;
            r_spawn      <= w_spawn_d;
            r_bonus      <= w_bonus_d;
            r_spawn_type <= w_spawn_type_d;
            r_win        <= w_win_d;
            r_lose       <= w_lose_d;
            r_bono_q     <= bus.bono_tomado;
        end
    end

    assign bus.tick        = w_tick;
    assign bus.spawn       = r_spawn;
    assign bus.spawn_type  = r_spawn_type;
    assign bus.bonus_spawn = r_bonus;
    assign bus.world       = r_world;
    assign bus.remaining   = r_remaining;
    assign bus.win         = r_win;
    assign bus.lose        = r_lose;

endmodule
